// File: rtl/config_loader_pkg.sv
// Shared definitions for the tile configuration loader: tile width,
// FSM state encoding and counter-width helpers.
package config_loader_pkg;

  localparam int TILE_CONFIG_BITS = 524;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Width of a counter that must hold every value 0..total_bits inclusive.
  function automatic int count_width(input int total_bits);
    return (total_bits < 1) ? 1 : $clog2(total_bits + 1);
  endfunction

  function automatic int index_width(input int word_width);
    return (word_width > 1) ? $clog2(word_width) : 1;
  endfunction

endpackage

// File: rtl/config_word_serializer.sv
// Parallel-in/serial-out word register: load a word, shift it out LSB-first,
// and flag the cycle that presents bit last_idx_i.
module config_word_serializer #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                                                  clock,
  input  logic                                                  nreset,
  input  logic                                                  load_i,
  input  logic                                                  shift_i,
  input  logic [WORD_WIDTH-1:0]                                 word_i,
  input  logic [config_loader_pkg::index_width(WORD_WIDTH)-1:0] last_idx_i,
  output logic                                                  bit_o,
  output logic                                                  last_bit_o
);
  import config_loader_pkg::*;

  localparam int IW = index_width(WORD_WIDTH);

  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]         bit_q, bit_d;

  // A load wins over a shift so the next word can follow the last bit with no bubble.
  always_comb begin
    shreg_d = shreg_q;
    bit_d   = bit_q;
    if (load_i) begin
      shreg_d = word_i;
      bit_d   = '0;
    end else if (shift_i) begin
      shreg_d = shreg_q >> 1;
      bit_d   = bit_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      shreg_q <= '0;
      bit_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
    end
  end

  assign bit_o      = shreg_q[0];
  assign last_bit_o = (bit_q == last_idx_i);

endmodule

// File: rtl/config_stream_loader.sv
// Streams host configuration words LSB-first onto the tile configuration chain,
// stopping after TILE_COUNT*TILE_CONFIG_BITS bits.
module config_stream_loader #(
  parameter int WORD_WIDTH       = 32,
  parameter int TILE_CONFIG_BITS = config_loader_pkg::TILE_CONFIG_BITS,
  parameter int TILE_COUNT       = 1
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_data,
  output logic                  config_enable,
  output logic                  busy,
  output logic                  done,
  output logic [config_loader_pkg::count_width(TILE_COUNT*TILE_CONFIG_BITS)-1:0] bits_loaded
);
  import config_loader_pkg::*;

  localparam int TOTAL_BITS = TILE_COUNT * TILE_CONFIG_BITS;
  localparam int CW         = count_width(TOTAL_BITS);
  localparam int IW         = index_width(WORD_WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TOTAL_BITS - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(WORD_WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          ser_load, ser_shift, ser_bit, ser_last;
  logic          ready_c, final_bit, word_last;

  config_word_serializer #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_ser (
    .clock      (clock),
    .nreset     (nreset),
    .load_i     (ser_load),
    .shift_i    (ser_shift),
    .word_i     (word_data),
    .last_idx_i (LAST_IDX),
    .bit_o      (ser_bit),
    .last_bit_o (ser_last)
  );

  // The final word may be partial: the total-bit count ends it early and the
  // unshifted upper bits are simply dropped.
  assign final_bit = (count_q == LAST_COUNT);
  assign word_last = ser_last || final_bit;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    ready_c   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_FETCH;
          count_d = '0;
        end
      end
      ST_FETCH: begin
        ready_c = 1'b1;
        if (word_valid) begin
          ser_load = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ser_shift = 1'b1;
        count_d   = count_q + 1'b1;
        if (final_bit) begin
          state_d = ST_DONE;
        end else if (word_last) begin
          ready_c = 1'b1;
          if (word_valid) begin
            ser_load = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including a coincident handshake.
    if (abort) begin
      state_d   = ST_IDLE;
      count_d   = count_q;
      ser_load  = 1'b0;
      ser_shift = 1'b0;
      ready_c   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign word_ready    = ready_c;
  assign config_data   = ser_bit;
  assign config_enable = (state_q == ST_SHIFT);
  assign busy          = (state_q == ST_FETCH) || (state_q == ST_SHIFT);
  assign done          = (state_q == ST_DONE);
  assign bits_loaded   = count_q;

endmodule

// File: tb/tb_config_stream_loader.sv
// Bench for config_stream_loader: one-tile and two-tile chains fed by a host model,
// with the shifted bits compared against the concatenated word stream.
module tb_config_stream_loader;

  localparam int WW     = 32;
  localparam int TOTAL1 = 524;
  localparam int TOTAL2 = 1048;
  localparam int NW1    = 17;
  localparam int NW2    = 33;

  logic clock;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic          nreset;
  logic          start, abort, word_valid;
  logic [WW-1:0] word_data;
  logic          word_ready, config_data, config_enable, busy, done;
  logic [9:0]    bits_loaded;

  logic          c2_start, c2_abort, c2_word_valid;
  logic [WW-1:0] c2_word_data;
  logic          c2_word_ready, c2_config_data, c2_config_enable, c2_busy, c2_done;
  logic [10:0]   c2_bits_loaded;

  config_stream_loader #(.WORD_WIDTH(WW), .TILE_CONFIG_BITS(524), .TILE_COUNT(1)) dut (
    .clock(clock), .nreset(nreset), .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .config_data(config_data), .config_enable(config_enable),
    .busy(busy), .done(done), .bits_loaded(bits_loaded)
  );

  config_stream_loader #(.WORD_WIDTH(WW), .TILE_CONFIG_BITS(524), .TILE_COUNT(2)) dut2 (
    .clock(clock), .nreset(nreset), .start(c2_start), .abort(c2_abort),
    .word_data(c2_word_data), .word_valid(c2_word_valid), .word_ready(c2_word_ready),
    .config_data(c2_config_data), .config_enable(c2_config_enable),
    .busy(c2_busy), .done(c2_done), .bits_loaded(c2_bits_loaded)
  );

  typedef struct {
    int          s_after;
    int          s_len;
    int          busy_bit;
    logic [31:0] last_word;
    int          exp_done;
    int          exp_span;
  } row_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] base_words[NW1];
  logic [31:0] words[$];
  bit          cap[$];
  int          widx, hs_cnt, en_cnt, en_first, en_last, cyc;
  int          stall_after, stall_len, stall_left;
  bit          stall_done;
  logic        last_ready, last_valid;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic load_setup(input int s_after, input int s_len, input logic [31:0] lw);
    words.delete();
    for (int i = 0; i < NW1; i++) words.push_back(base_words[i]);
    words[NW1-1] = lw;
    cap.delete();
    widx = 0; hs_cnt = 0; en_cnt = 0; en_first = -1; en_last = -1; cyc = 0;
    stall_after = s_after; stall_len = s_len; stall_left = 0; stall_done = 1'b0;
  endtask

  // One clock of the host model: present inputs, note the handshake, then sample
  // the chain-side outputs just after the edge.
  task automatic step1(input bit st, input bit ab);
    start = st;
    abort = ab;
    #1;
    if (!stall_done && stall_after >= 0 && hs_cnt == stall_after && word_ready) begin
      stall_left = stall_len;
      stall_done = 1'b1;
    end
    word_valid = (stall_left == 0) && (widx < words.size());
    if (stall_left > 0) stall_left--;
    word_data = (widx < words.size()) ? words[widx] : 32'h0;
    #1;
    last_ready = word_ready;
    last_valid = word_valid;
    if (word_valid && word_ready) begin
      widx++;
      hs_cnt++;
    end
    @(posedge clock);
    #1;
    cyc++;
    start = 1'b0;
    abort = 1'b0;
    if (config_enable) begin
      cap.push_back(config_data);
      en_cnt++;
      if (en_first < 0) en_first = cyc;
      en_last = cyc;
    end
  endtask

  task automatic run_load(input int s_after, input int s_len, input int busy_bit,
                          input logic [31:0] lw, output int done_cyc);
    bit fired;
    int k;
    fired = 1'b0;
    k = 0;
    done_cyc = -1;
    load_setup(s_after, s_len, lw);
    step1(1'b1, 1'b0);
    check("start_busy", busy, 1);
    check("start_count_clear", bits_loaded, 0);
    check("start_done_low", done, 0);
    while (done_cyc < 0 && k < 3000) begin
      if (done) begin
        done_cyc = cyc - 1;
      end else if (busy_bit >= 0 && !fired && int'(bits_loaded) == busy_bit) begin
        fired = 1'b1;
        step1(1'b1, 1'b0);
        check("start_ignored_count", bits_loaded, busy_bit + 1);
        check("start_ignored_busy", busy, 1);
      end else begin
        step1(1'b0, 1'b0);
      end
      k++;
    end
  endtask

  task automatic check_load(input int exp_done, input int exp_span, input int done_cyc,
                            input logic [31:0] lw);
    int          bad;
    logic [31:0] w;
    logic [11:0] tail;
    bad = 0;
    check("done_latency", done_cyc, exp_done);
    check("handshakes", hs_cnt, NW1);
    check("enable_cycles", en_cnt, TOTAL1);
    check("enable_span", en_last - en_first + 1, exp_span);
    check("bits_loaded_end", bits_loaded, TOTAL1);
    check("done_level", done, 1);
    check("busy_in_done", busy, 0);
    check("enable_in_done", config_enable, 0);
    check("stream_len", cap.size(), TOTAL1);
    for (int i = 0; i < TOTAL1 && i < cap.size(); i++) begin
      w = words[i / WW];
      if (cap[i] !== w[i % WW]) bad++;
    end
    check("stream_bits", bad, 0);
    for (int j = 0; j < 12; j++) tail[j] = (512 + j < cap.size()) ? cap[512 + j] : 1'bx;
    check("tail12", tail, lw[11:0]);
  endtask

  task automatic abort_at(input int n);
    int k;
    int w_before;
    k = 0;
    load_setup(-1, 0, 32'hFFFFF5A5);
    step1(1'b1, 1'b0);
    while (int'(bits_loaded) != n && k < 2000) begin
      step1(1'b0, 1'b0);
      k++;
    end
    check("abort_reach", bits_loaded, n);
    w_before = widx;
    step1(1'b0, 1'b1);
    check("abort_ready_low", last_ready, 0);
    check("abort_valid_high", last_valid, 1);
    check("abort_enable", config_enable, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    check("abort_word_kept", widx, w_before);
    step1(1'b0, 1'b0);
    check("abort_stays_idle", busy, 0);
  endtask

  task automatic run_tc2();
    logic [31:0] w2[$];
    logic [31:0] w;
    logic [23:0] tail;
    bit          cap2[$];
    int          idx, hs, c, dc, bad;
    idx = 0; hs = 0; c = 0; dc = -1; bad = 0;
    for (int i = 0; i < NW2; i++) w2.push_back($urandom);
    c2_start = 1'b1;
    @(posedge clock);
    #1;
    c = 1;
    c2_start = 1'b0;
    while (dc < 0 && c < 3000) begin
      c2_word_valid = (idx < NW2);
      c2_word_data  = (idx < NW2) ? w2[idx] : 32'h0;
      #1;
      if (c2_word_valid && c2_word_ready) begin
        idx++;
        hs++;
      end
      @(posedge clock);
      #1;
      c++;
      if (c2_config_enable) cap2.push_back(c2_config_data);
      if (c2_done) dc = c - 1;
    end
    c2_word_valid = 1'b0;
    check("tc2_done_latency", dc, TOTAL2 + 1);
    check("tc2_handshakes", hs, NW2);
    check("tc2_bits_loaded", c2_bits_loaded, TOTAL2);
    check("tc2_stream_len", cap2.size(), TOTAL2);
    for (int i = 0; i < TOTAL2 && i < cap2.size(); i++) begin
      w = w2[i / WW];
      if (cap2[i] !== w[i % WW]) bad++;
    end
    check("tc2_stream_bits", bad, 0);
    w = w2[NW2-1];
    for (int j = 0; j < 24; j++) tail[j] = (1024 + j < cap2.size()) ? cap2[1024 + j] : 1'bx;
    check("tc2_tail24", tail, w[23:0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t rows[5];
    int   dcyc;

    rows[0] = '{s_after: -1, s_len: 0, busy_bit: -1, last_word: 32'hFFFFF5A5, exp_done: 525, exp_span: 524};
    rows[1] = '{s_after:  3, s_len: 5, busy_bit: -1, last_word: 32'hFFFFF5A5, exp_done: 530, exp_span: 529};
    rows[2] = '{s_after: -1, s_len: 0, busy_bit: 50, last_word: 32'h12345A5A, exp_done: 525, exp_span: 524};
    rows[3] = '{s_after:  0, s_len: 3, busy_bit: -1, last_word: 32'h00000FFF, exp_done: 528, exp_span: 524};
    rows[4] = '{s_after: 10, s_len: 2, busy_bit: -1, last_word: 32'hFFFFF5A5, exp_done: 527, exp_span: 526};

    nreset = 1'b0;
    start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_data = '0;
    c2_start = 1'b0; c2_abort = 1'b0; c2_word_valid = 1'b0; c2_word_data = '0;
    for (int i = 0; i < NW1; i++) base_words[i] = $urandom;
    #1;
    check("rst_enable", config_enable, 0);
    check("rst_data", config_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", word_ready, 0);
    check("rst_bits_loaded", bits_loaded, 0);
    check("rst_tc2_bits_loaded", c2_bits_loaded, 0);

    @(negedge clock);
    nreset = 1'b1;
    @(posedge clock);
    #1;
    load_setup(-1, 0, 32'hFFFFF5A5);
    step1(1'b0, 1'b0);
    step1(1'b0, 1'b0);
    check("idle_no_start_busy", busy, 0);
    check("idle_no_start_hs", hs_cnt, 0);

    for (int r = 0; r < 5; r++) begin
      run_load(rows[r].s_after, rows[r].s_len, rows[r].busy_bit, rows[r].last_word, dcyc);
      check_load(rows[r].exp_done, rows[r].exp_span, dcyc, rows[r].last_word);
    end

    abort_at(100);
    run_load(-1, 0, -1, 32'hFFFFF5A5, dcyc);
    check_load(525, 524, dcyc, 32'hFFFFF5A5);
    abort_at(95);

    // Asynchronous reset in the middle of a shift.
    load_setup(-1, 0, 32'hFFFFF5A5);
    step1(1'b1, 1'b0);
    for (int k = 0; k < 2000 && int'(bits_loaded) != 200; k++) step1(1'b0, 1'b0);
    #2;
    nreset = 1'b0;
    #1;
    check("arst_enable", config_enable, 0);
    check("arst_data", config_data, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_ready", word_ready, 0);
    check("arst_bits_loaded", bits_loaded, 0);
    @(negedge clock);
    nreset = 1'b1;
    @(posedge clock);
    #1;
    load_setup(-1, 0, 32'hFFFFF5A5);
    for (int k = 0; k < 3; k++) step1(1'b0, 1'b0);
    check("arst_needs_start_busy", busy, 0);
    check("arst_needs_start_en", en_cnt, 0);
    run_load(-1, 0, -1, 32'hFFFFF5A5, dcyc);
    check_load(525, 524, dcyc, 32'hFFFFF5A5);

    run_tc2();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
